// File: rtl/line_burst_pkg.sv
// rtl/line_burst_pkg.sv - shared state encoding and sizing helpers for the line burst adapter
package line_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_e;

    function automatic int beats_f(input int line_w, input int bus_w);
        return line_w / bus_w;
    endfunction

    function automatic bit is_pow2_f(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// rtl/line_burst_adapter_if.sv - cache-side line request and memory-side burst signals
interface line_burst_adapter_if #(
    parameter int LINE_W = 256,
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address_i;
    logic              read_i;
    logic              write_i;
    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic              resp_o;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic [BUS_W-1:0]  burst_o;
    logic [BUS_W-1:0]  burst_i;
    logic              resp_i;

    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/line_burst_adapter.sv
// rtl/line_burst_adapter.sv - splits cache-line reads/writes into BUS_W beats on the memory bus
module line_burst_adapter
    import line_burst_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 32
) (
    input logic                clk,
    input logic                rst,
    line_burst_adapter_if.slave bus
);

    localparam int BEATS  = beats_f(LINE_W, BUS_W);
    localparam int OFFSET = $clog2(LINE_W / 8);
    localparam int CNT_W  = $clog2(BEATS);

    generate
        if ((LINE_W % BUS_W) != 0 || !is_pow2_f(BEATS)) begin : g_param_check
            $error("line_burst_adapter: LINE_W/BUS_W must be a power of 2 >= 2");
        end
    endgenerate

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  beat_cnt;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_q;
    logic [ADDR_W-1:0] address_q;
    logic              last_beat;
    logic              unused_addr_bits;

    // Byte offset within the line never reaches memory.
    assign unused_addr_bits = ^bus.address_i[OFFSET-1:0];

    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.read_i) begin
                    state_d = RD_BURST;
                end else if (bus.write_i) begin
                    state_d = WR_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (bus.resp_i && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            line_buf  <= '0;
            line_q    <= '0;
            address_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.read_i || bus.write_i) begin
                        address_q <= {bus.address_i[ADDR_W-1:OFFSET], {OFFSET{1'b0}}};
                    end
                    if (!bus.read_i && bus.write_i) begin
                        line_buf <= bus.line_i;
                    end
                end
                RD_BURST: begin
                    if (bus.resp_i) begin
                        line_buf[int'(beat_cnt)*BUS_W +: BUS_W] <= bus.burst_i;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        // Publish on the last beat so line_o is valid during DONE.
                        if (last_beat) begin
                            line_q <= {bus.burst_i, line_buf[LINE_W-BUS_W-1:0]};
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.resp_i) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.burst_o = '0;
        if (state_q == WR_BURST) begin
            bus.burst_o = line_buf[int'(beat_cnt)*BUS_W +: BUS_W];
        end
    end

    assign bus.read_o    = (state_q == RD_BURST);
    assign bus.write_o   = (state_q == WR_BURST);
    assign bus.resp_o    = (state_q == DONE);
    assign bus.line_o    = line_q;
    assign bus.address_o = address_q;

endmodule
